// File: rtl/rx_serial_7e1.sv
// 7E1 asynchronous serial receiver: start, 7 data bits LSB first, even parity, stop.
// Latency: pronto one cycle after the stop sample; pin-to-linha is 1 cycle (3 with RX_SERIAL_SYNC2_EN).
// No backpressure: each frame overwrites dados_ascii/flags; tem_dado stays set until limpa.
module rx_serial_7e1 #(
    parameter int M_BAUD = 434,
    parameter int N_BAUD = 9
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       entrada_serial,
    input  logic       limpa,
    output logic [6:0] dados_ascii,
    output logic       pronto,
    output logic       tem_dado,
    output logic       erro_paridade,
    output logic       erro_parada,
    output logic [3:0] db_estado
);

    localparam logic [N_BAUD-1:0] T_HALF = N_BAUD'(M_BAUD / 2);
    localparam logic [N_BAUD-1:0] T_LAST = N_BAUD'(M_BAUD - 1);

    typedef enum logic [3:0] {
        INICIAL  = 4'd0,
        START    = 4'd1,
        DADOS    = 4'd2,
        PARIDADE = 4'd3,
        PARADA   = 4'd4,
        FINAL    = 4'd5
    } estado_t;

    estado_t             estado_q, estado_d;
    logic [N_BAUD-1:0]   timer_q, timer_d;
    logic [2:0]          bit_cnt_q, bit_cnt_d;
    logic [6:0]          shift_q, shift_d;
    logic                par_q, par_d;
    logic                stop_q, stop_d;
    logic [6:0]          dados_q, dados_d;
    logic                erro_par_q, erro_par_d;
    logic                erro_stop_q, erro_stop_d;
    logic                tem_dado_q, tem_dado_d;
    logic                linha_q, linha_ant_q;

`ifdef RX_SERIAL_SYNC2_EN
    logic [1:0] sync_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync_q  <= 2'b11;
            linha_q <= 1'b1;
        end else begin
            sync_q  <= {sync_q[0], entrada_serial};
            linha_q <= sync_q[1];
        end
    end
`else
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            linha_q <= 1'b1;
        end else begin
            linha_q <= entrada_serial;
        end
    end
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            linha_ant_q <= 1'b1;
            estado_q    <= INICIAL;
            timer_q     <= '0;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            par_q       <= 1'b0;
            stop_q      <= 1'b0;
            dados_q     <= '0;
            erro_par_q  <= 1'b0;
            erro_stop_q <= 1'b0;
            tem_dado_q  <= 1'b0;
        end else begin
            linha_ant_q <= linha_q;
            estado_q    <= estado_d;
            timer_q     <= timer_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            par_q       <= par_d;
            stop_q      <= stop_d;
            dados_q     <= dados_d;
            erro_par_q  <= erro_par_d;
            erro_stop_q <= erro_stop_d;
            tem_dado_q  <= tem_dado_d;
        end
    end

    always_comb begin
        estado_d    = estado_q;
        timer_d     = timer_q + 1'b1;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        par_d       = par_q;
        stop_d      = stop_q;
        dados_d     = dados_q;
        erro_par_d  = erro_par_q;
        erro_stop_d = erro_stop_q;
        tem_dado_d  = tem_dado_q;
        pronto      = 1'b0;

        if (limpa) begin
            tem_dado_d = 1'b0;
        end

        case (estado_q)
            INICIAL: begin
                timer_d   = '0;
                bit_cnt_d = '0;
                // Edge-triggered so a line held low cannot start frames repeatedly.
                if (linha_ant_q && !linha_q) begin
                    estado_d = START;
                end
            end
            START: begin
                if (timer_q == T_HALF) begin
                    timer_d  = '0;
                    estado_d = linha_q ? INICIAL : DADOS;
                end
            end
            DADOS: begin
                if (timer_q == T_LAST) begin
                    timer_d   = '0;
                    shift_d   = {linha_q, shift_q[6:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd6) begin
                        estado_d = PARIDADE;
                    end
                end
            end
            PARIDADE: begin
                if (timer_q == T_LAST) begin
                    timer_d  = '0;
                    par_d    = linha_q;
                    estado_d = PARADA;
                end
            end
            PARADA: begin
                if (timer_q == T_LAST) begin
                    timer_d  = '0;
                    stop_d   = linha_q;
                    estado_d = FINAL;
                end
            end
            FINAL: begin
                timer_d     = '0;
                dados_d     = shift_q;
                erro_par_d  = ^{shift_q, par_q};
                erro_stop_d = ~stop_q;
                pronto      = 1'b1;
                // Set overrides a simultaneous limpa.
                tem_dado_d  = 1'b1;
                estado_d    = INICIAL;
            end
            default: begin
                timer_d  = '0;
                estado_d = INICIAL;
            end
        endcase
    end

    assign dados_ascii   = dados_q;
    assign tem_dado      = tem_dado_q;
    assign erro_paridade = erro_par_q;
    assign erro_parada   = erro_stop_q;
    assign db_estado     = estado_q;

endmodule

// File: tb/tb_rx_serial_7e1.sv
// Directed bench for rx_serial_7e1 with M_BAUD=16: frames, errors, glitch, reset, limpa.
module tb_rx_serial_7e1;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       entrada_serial = 1'b1;
    logic       limpa = 1'b0;
    logic [6:0] dados_ascii;
    logic       pronto;
    logic       tem_dado;
    logic       erro_paridade;
    logic       erro_parada;
    logic [3:0] db_estado;

    int n_checks = 0;
    int n_fail   = 0;
    int pronto_cnt = 0;
    logic pronto_d1 = 1'b0;
    logic [6:0] rx_log[$];

    rx_serial_7e1 #(.M_BAUD(16), .N_BAUD(5)) dut (
        .clock          (clock),
        .reset          (reset),
        .entrada_serial (entrada_serial),
        .limpa          (limpa),
        .dados_ascii    (dados_ascii),
        .pronto         (pronto),
        .tem_dado       (tem_dado),
        .erro_paridade  (erro_paridade),
        .erro_parada    (erro_parada),
        .db_estado      (db_estado)
    );

    always #5 clock = ~clock;

    // Count pronto cycles and log the character registered one cycle after each pulse.
    always @(negedge clock) begin
        if (pronto_d1) rx_log.push_back(dados_ascii);
        pronto_d1 = pronto;
        if (pronto) pronto_cnt++;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic drive_bit(input logic b);
        entrada_serial = b;
        repeat (16) @(negedge clock);
    endtask

    task automatic send_frame(input logic [6:0] d, input logic p, input logic s);
        drive_bit(1'b0);
        for (int i = 0; i < 7; i++) drive_bit(d[i]);
        drive_bit(p);
        drive_bit(s);
        entrada_serial = 1'b1;
    endtask

    int   p0;
    int   n0;
    logic found;

    initial begin
        // Reset state
        idle(3);
        check_eq("rst_dados", dados_ascii, 0);
        check_eq("rst_pronto", pronto, 0);
        check_eq("rst_tem_dado", tem_dado, 0);
        check_eq("rst_erro_par", erro_paridade, 0);
        check_eq("rst_erro_stop", erro_parada, 0);
        check_eq("rst_estado", db_estado, 0);
        reset = 1'b0;
        idle(10);

        // 1. 'A'
        p0 = pronto_cnt;
        send_frame(7'h41, 1'b0, 1'b1);
        idle(4);
        check_eq("t1_pronto_cnt", pronto_cnt, p0 + 1);
        check_eq("t1_dados", dados_ascii, 7'h41);
        check_eq("t1_erro_par", erro_paridade, 0);
        check_eq("t1_erro_stop", erro_parada, 0);
        check_eq("t1_tem_dado", tem_dado, 1);
        check_eq("t1_estado", db_estado, 0);

        // 2. back-to-back 0x37 / 0x33
        p0 = pronto_cnt;
        n0 = rx_log.size();
        send_frame(7'h37, 1'b1, 1'b1);
        send_frame(7'h33, 1'b0, 1'b1);
        idle(4);
        check_eq("t2_pronto_cnt", pronto_cnt, p0 + 2);
        check_eq("t2_log_size", rx_log.size(), n0 + 2);
        if (rx_log.size() >= n0 + 2) begin
            check_eq("t2_first", rx_log[n0], 7'h37);
            check_eq("t2_second", rx_log[n0 + 1], 7'h33);
        end
        check_eq("t2_erro_par", erro_paridade, 0);
        check_eq("t2_erro_stop", erro_parada, 0);

        // 3. parity error, then stop error
        idle(10);
        send_frame(7'h37, 1'b0, 1'b1);
        idle(4);
        check_eq("t3_dados_par", dados_ascii, 7'h37);
        check_eq("t3_erro_par", erro_paridade, 1);
        check_eq("t3_erro_stop_a", erro_parada, 0);
        p0 = pronto_cnt;
        send_frame(7'h41, 1'b0, 1'b0);
        idle(4);
        check_eq("t3_pronto_cnt", pronto_cnt, p0 + 1);
        check_eq("t3_dados_stop", dados_ascii, 7'h41);
        check_eq("t3_erro_stop_b", erro_parada, 1);
        check_eq("t3_erro_par_b", erro_paridade, 0);

        // 4. glitch shorter than half a bit
        idle(20);
        p0 = pronto_cnt;
        entrada_serial = 1'b0;
        idle(5);
        entrada_serial = 1'b1;
        idle(30);
        check_eq("t4_no_pronto", pronto_cnt, p0);
        check_eq("t4_estado", db_estado, 0);
        check_eq("t4_dados_held", dados_ascii, 7'h41);
        check_eq("t4_erro_stop_held", erro_parada, 1);

        // 5. reset in the middle of bit 3 of 0x41
        p0 = pronto_cnt;
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b0);
        drive_bit(1'b0);
        entrada_serial = 1'b0;
        idle(8);
        reset = 1'b1;
        #1;
        check_eq("t5_rst_dados", dados_ascii, 0);
        check_eq("t5_rst_tem_dado", tem_dado, 0);
        check_eq("t5_rst_erro_stop", erro_parada, 0);
        check_eq("t5_rst_estado", db_estado, 0);
        entrada_serial = 1'b1;
        idle(3);
        reset = 1'b0;
        idle(200);
        check_eq("t5_no_partial", pronto_cnt, p0);
        send_frame(7'h33, 1'b0, 1'b1);
        idle(4);
        check_eq("t5_after_dados", dados_ascii, 7'h33);
        check_eq("t5_after_erro_par", erro_paridade, 0);
        check_eq("t5_after_tem_dado", tem_dado, 1);

        // 6. limpa alone, then limpa coinciding with pronto
        limpa = 1'b1;
        idle(1);
        limpa = 1'b0;
        idle(1);
        check_eq("t6_limpa_clears", tem_dado, 0);
        found = 1'b0;
        fork
            send_frame(7'h41, 1'b0, 1'b1);
            begin
                for (int i = 0; i < 400 && !found; i++) begin
                    @(negedge clock);
                    if (pronto) begin
                        found = 1'b1;
                        limpa = 1'b1;
                        @(negedge clock);
                        limpa = 1'b0;
                    end
                end
            end
        join
        idle(2);
        check_eq("t6_pronto_seen", found, 1);
        check_eq("t6_set_wins", tem_dado, 1);
        check_eq("t6_dados", dados_ascii, 7'h41);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
